apb_reset_sequencer: RTL and testbench



---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_rst_timer.sv | 32 +++
 rtl/apb_reset_sequencer.sv | 155 +++++++++++++++
 tb/tb_apb_reset_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB-side constants and types, including the reset sequencer's
// default sizing and its state encoding.
package apb_pkg;

    localparam int RST_NUM_CHANNELS   = 4;
    localparam int RST_HOLD_CYCLES    = 4;
    localparam int RST_STAGGER_CYCLES = 2;
    localparam int RST_CNT_WIDTH      = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        ACK     = 2'd3
    } rst_seq_state_t;

endpackage

// File: rtl/apb_rst_timer.sv
// Loadable saturating down-counter shared by the hold and stagger phases.
// A load of N produces an expire pulse N edges after the loading edge;
// a count of zero means the timer is idle.
module apb_rst_timer #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 load,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic                 expire,
    output logic                 idle
);

    logic [CNT_WIDTH-1:0] count;

    // Load takes priority; otherwise count down while enabled, stopping at zero.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

    assign expire = en && (count == CNT_WIDTH'(1));
    assign idle   = (count == '0);

endmodule

// File: rtl/apb_reset_sequencer.sv
// Multi-channel reset sequencer: holds selected peripheral resets low,
// then releases them in ascending index order with a programmable stagger.
// Power-on runs the same sequence on every channel but skips the ack phase.
module apb_reset_sequencer
    import apb_pkg::*;
#(
    parameter int NUM_CHANNELS   = RST_NUM_CHANNELS,
    parameter int HOLD_CYCLES    = RST_HOLD_CYCLES,
    parameter int STAGGER_CYCLES = RST_STAGGER_CYCLES,
    parameter int CNT_WIDTH      = RST_CNT_WIDTH
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    soft_rst_req,
    input  logic [NUM_CHANNELS-1:0] soft_rst_mask,
    output logic [NUM_CHANNELS-1:0] ch_rstn,
    output logic                    soft_rst_ack,
    output logic                    seq_busy,
    output logic                    seq_done
);

    rst_seq_state_t          state;
    logic [NUM_CHANNELS-1:0] active_mask;
    logic [NUM_CHANNELS-1:0] lowest;
    logic [NUM_CHANNELS-1:0] rel_bits;
    logic [NUM_CHANNELS-1:0] remaining;
    logic                    por_seq;
    logic                    accept;
    logic                    do_release;
    logic                    tmr_load;
    logic                    tmr_en;
    logic                    tmr_expire;
    logic                    tmr_idle;
    logic [CNT_WIDTH-1:0]    tmr_load_val;

    // active_mask holds the channels still waiting to be released, so it
    // shrinks as the sequence progresses and is empty when it completes.
    assign accept    = soft_rst_req && !soft_rst_ack;
    assign lowest    = active_mask & (~active_mask + NUM_CHANNELS'(1));
    assign rel_bits  = (STAGGER_CYCLES == 0) ? active_mask : lowest;
    assign remaining = active_mask & ~rel_bits;
    assign tmr_en    = (state == HOLD) || (state == RELEASE);

    apb_rst_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .pclk     (pclk),
        .presetn  (presetn),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_load_val),
        .expire   (tmr_expire),
        .idle     (tmr_idle)
    );

    // Decide when a release happens and how the shared timer is (re)armed;
    // an idle timer on entry to HOLD is armed for the remainder of the hold.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        do_release   = 1'b0;
        case (state)
            IDLE: begin
                tmr_load = accept;
            end
            HOLD: begin
                if (tmr_expire || (tmr_idle && (HOLD_CYCLES == 1))) begin
                    do_release = 1'b1;
                end else if (tmr_idle) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_WIDTH'(HOLD_CYCLES - 1);
                end
            end
            RELEASE: begin
                do_release = (active_mask != '0) && tmr_expire;
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
        if (do_release && (remaining != '0) && (STAGGER_CYCLES != 0)) begin
            tmr_load     = 1'b1;
            tmr_load_val = CNT_WIDTH'(STAGGER_CYCLES);
        end
    end

    // Sequencer state machine with all outputs registered alongside the state.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state        <= HOLD;
            active_mask  <= '1;
            ch_rstn      <= '0;
            soft_rst_ack <= 1'b0;
            seq_busy     <= 1'b0;
            seq_done     <= 1'b0;
            por_seq      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    seq_busy     <= 1'b0;
                    seq_done     <= 1'b1;
                    soft_rst_ack <= 1'b0;
                    if (accept) begin
                        active_mask <= soft_rst_mask;
                        seq_done    <= 1'b0;
                        if (soft_rst_mask != '0) begin
                            ch_rstn  <= ch_rstn & ~soft_rst_mask;
                            seq_busy <= 1'b1;
                            state    <= HOLD;
                        end else begin
                            soft_rst_ack <= 1'b1;
                            state        <= ACK;
                        end
                    end
                end
                HOLD: begin
                    seq_busy <= 1'b1;
                    if (do_release) begin
                        ch_rstn     <= ch_rstn | rel_bits;
                        active_mask <= remaining;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    seq_busy <= 1'b1;
                    if (active_mask == '0) begin
                        seq_busy <= 1'b0;
                        if (por_seq) begin
                            por_seq  <= 1'b0;
                            seq_done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            soft_rst_ack <= 1'b1;
                            state        <= ACK;
                        end
                    end else if (do_release) begin
                        ch_rstn     <= ch_rstn | rel_bits;
                        active_mask <= remaining;
                    end
                end
                ACK: begin
                    if (!soft_rst_req) begin
                        soft_rst_ack <= 1'b0;
                        seq_done     <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_reset_sequencer.sv
// Bench for apb_reset_sequencer: one instance with default stagger and one
// with zero stagger, compared cycle by cycle against expected output vectors.
module tb_apb_reset_sequencer;

    localparam int HOLD = 4;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       req = 1'b0;
    logic [3:0] mask = 4'b0000;
    logic [3:0] ch_rstn;
    logic       ack, busy, done;
    logic       s0_req = 1'b0;
    logic [3:0] s0_mask = 4'b0000;
    logic [3:0] s0_ch_rstn;
    logic       s0_ack, s0_busy, s0_done;

    int n_vec = 0;
    int n_err = 0;
    logic [13:0] exp_q[$];

    wire [13:0] obs = {ch_rstn, ack, busy, done, s0_ch_rstn, s0_ack, s0_busy, s0_done};
    localparam logic [6:0] IDLE_V  = 7'b1111_001;
    localparam logic [6:0] RESET_V = 7'b0000_000;

    apb_reset_sequencer #(
        .NUM_CHANNELS(4), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(2), .CNT_WIDTH(8)
    ) dut (
        .pclk(pclk), .presetn(presetn), .soft_rst_req(req), .soft_rst_mask(mask),
        .ch_rstn(ch_rstn), .soft_rst_ack(ack), .seq_busy(busy), .seq_done(done)
    );

    apb_reset_sequencer #(
        .NUM_CHANNELS(4), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(0), .CNT_WIDTH(8)
    ) dut_s0 (
        .pclk(pclk), .presetn(presetn), .soft_rst_req(s0_req), .soft_rst_mask(s0_mask),
        .ch_rstn(s0_ch_rstn), .soft_rst_ack(s0_ack), .seq_busy(s0_busy), .seq_done(s0_done)
    );

    always #5 pclk = ~pclk;

    // Expected {ch_rstn, ack, busy, done} k edges after the hold-entry edge:
    // the j-th selected channel rises at k = HOLD + j*stg.
    function automatic logic [6:0] seq_exp(int k, logic [3:0] m, bit por, int stg);
        logic [3:0] ch;
        int j;
        int last;
        logic b, a, d;
        ch = ~m;
        j = 0;
        last = HOLD;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                last = HOLD + j * stg;
                if (k >= last) ch[i] = 1'b1;
                j++;
            end
        end
        b = por ? (k >= 1 && k <= last) : (k <= last);
        d = por && (k > last);
        a = !por && (k > last);
        return {ch, a, b, d};
    endfunction

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] e;
        presetn = 1'b0;
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back({RESET_V, RESET_V});
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("[TB] FAIL reset c=%0d: got %b expected %b", c, obs, e);
            end
        end
    endtask

    task automatic test_power_on();
        logic [13:0] e;
        presetn = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            exp_q.push_back({seq_exp(k, 4'b1111, 1'b1, 2), seq_exp(k, 4'b1111, 1'b1, 0)});
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("[TB] FAIL power_on k=%0d: got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_soft_mask();
        logic [13:0] e;
        mask = 4'b1010;
        req  = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            if (k <= 9) exp_q.push_back({seq_exp(k, 4'b1010, 1'b0, 2), IDLE_V});
            else        exp_q.push_back({IDLE_V, IDLE_V});
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("[TB] FAIL soft_mask k=%0d: got %b expected %b", k, obs, e);
            end
            if (k == 2) mask = 4'b0101;
            if (k == 9) req = 1'b0;
        end
        mask = 4'b0000;
    endtask

    task automatic test_zero_mask();
        logic [13:0] e;
        mask = 4'b0000;
        req  = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            if (k <= 1) exp_q.push_back({7'b1111_100, IDLE_V});
            else        exp_q.push_back({IDLE_V, IDLE_V});
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("[TB] FAIL zero_mask k=%0d: got %b expected %b", k, obs, e);
            end
            if (k == 1) req = 1'b0;
        end
    endtask

    task automatic test_stagger0();
        logic [13:0] e;
        s0_mask = 4'b1111;
        s0_req  = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k <= 6) exp_q.push_back({IDLE_V, seq_exp(k, 4'b1111, 1'b0, 0)});
            else        exp_q.push_back({IDLE_V, IDLE_V});
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("[TB] FAIL stagger0 k=%0d: got %b expected %b", k, obs, e);
            end
            if (k == 6) s0_req = 1'b0;
        end
        s0_mask = 4'b0000;
    endtask

    task automatic test_back_to_back();
        logic [13:0] e;
        mask = 4'b1010;
        req  = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            if (k <= 6)      exp_q.push_back({seq_exp(k, 4'b1010, 1'b0, 2), IDLE_V});
            else if (k == 7) exp_q.push_back({7'b1111_100, IDLE_V});
            else             exp_q.push_back({IDLE_V, IDLE_V});
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("[TB] FAIL back_to_back k=%0d: got %b expected %b", k, obs, e);
            end
            if (k == 0) req = 1'b0;
            if (k == 4) begin
                req  = 1'b1;
                mask = 4'b0101;
            end
            if (k == 5) req = 1'b0;
        end
        mask = 4'b0000;
    endtask

    task automatic test_abort();
        logic [13:0] e;
        mask = 4'b0001;
        req  = 1'b1;
        for (int k = 0; k <= 2; k++) begin
            exp_q.push_back({seq_exp(k, 4'b0001, 1'b0, 2), IDLE_V});
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("[TB] FAIL abort_hold k=%0d: got %b expected %b", k, obs, e);
            end
        end
        presetn = 1'b0;
        req     = 1'b0;
        exp_q.push_back({RESET_V, RESET_V});
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("[TB] FAIL abort_reset: got %b expected %b", obs, e);
        end
        test_power_on();
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_soft_mask();
        test_zero_mask();
        test_stagger0();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
